// File: rtl/pa3x3_tile_controller.sv
// Tile sequencer for processing_array_3x3: clears the accumulators, streams K operand
// pairs from synchronous memory, waits for done, then presents the result to a consumer.
module pa3x3_tile_controller #(
   parameter int DATA_WIDTH    = 8,
   parameter int ACC_WIDTH     = 32,
   parameter int ADDR_WIDTH    = 8,
   parameter int K_WIDTH       = 8,
   parameter int DRAIN_TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic [K_WIDTH-1:0]      i_k_len,
   input  logic [ADDR_WIDTH-1:0]   i_a_base,
   input  logic [ADDR_WIDTH-1:0]   i_b_base,
   output logic                    o_busy,
   output logic                    o_mem_rd_en,
   output logic [ADDR_WIDTH-1:0]   o_a_addr,
   output logic [ADDR_WIDTH-1:0]   o_b_addr,
   input  logic [3*DATA_WIDTH-1:0] i_a_rdata,
   input  logic [3*DATA_WIDTH-1:0] i_b_rdata,
   output logic [3*DATA_WIDTH-1:0] o_pa_a_vector,
   output logic [3*DATA_WIDTH-1:0] o_pa_b_vector,
   output logic                    o_pa_data_valid,
   output logic                    o_pa_read_enable,
   output logic                    o_pa_clear_acc,
   input  logic [9*ACC_WIDTH-1:0]  i_pa_result_matrix,
   input  logic                    i_pa_computation_done,
   input  logic                    i_pa_overflow_detected,
   output logic [9*ACC_WIDTH-1:0]  o_result_matrix,
   output logic                    o_result_valid,
   input  logic                    i_result_ready,
   output logic                    o_overflow,
   output logic                    o_timeout_err,
   output logic [2:0]              o_dbg_state
);

   localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [DW-1:0]      DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
   localparam logic [K_WIDTH-1:0] K_ONE      = K_WIDTH'(1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLEAR   = 3'd1;
   localparam logic [2:0] S_FETCH   = 3'd2;
   localparam logic [2:0] S_DRAIN   = 3'd3;
   localparam logic [2:0] S_READ    = 3'd4;
   localparam logic [2:0] S_CAPTURE = 3'd5;
   localparam logic [2:0] S_HOLD    = 3'd6;

   logic [2:0]            state;
   logic [K_WIDTH-1:0]    k_len;
   logic [K_WIDTH-1:0]    fetch_idx;
   logic [ADDR_WIDTH-1:0] a_base;
   logic [ADDR_WIDTH-1:0] b_base;
   logic [DW-1:0]         drain_cnt;
   logic                  overflow_acc;
   logic                  rd_en_d1;
   logic                  start_ok;
   logic                  ovf_window;

   assign start_ok   = (state == S_IDLE) && i_start && (i_k_len != '0);
   assign ovf_window = (state == S_CLEAR) || (state == S_FETCH) || (state == S_DRAIN) ||
                       (state == S_READ) || (state == S_CAPTURE);

   assign o_busy           = (state != S_IDLE);
   assign o_mem_rd_en      = (state == S_FETCH);
   assign o_a_addr         = o_mem_rd_en ? a_base + ADDR_WIDTH'(fetch_idx) : '0;
   assign o_b_addr         = o_mem_rd_en ? b_base + ADDR_WIDTH'(fetch_idx) : '0;
   assign o_pa_clear_acc   = (state == S_CLEAR);
   assign o_pa_read_enable = (state == S_READ);
   assign o_dbg_state      = state;

   // Result handshake: o_result_valid is high for the whole of HOLD with o_result_matrix and
   // o_overflow frozen; a transfer occurs on any cycle where valid and i_result_ready are both high.
   assign o_result_valid = (state == S_HOLD);

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state           <= S_IDLE;
         k_len           <= '0;
         fetch_idx       <= '0;
         a_base          <= '0;
         b_base          <= '0;
         drain_cnt       <= '0;
         overflow_acc    <= 1'b0;
         o_result_matrix <= '0;
         o_overflow      <= 1'b0;
         o_timeout_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  k_len         <= i_k_len;
                  a_base        <= i_a_base;
                  b_base        <= i_b_base;
                  fetch_idx     <= '0;
                  o_overflow    <= 1'b0;
                  o_timeout_err <= 1'b0;
                  state         <= S_CLEAR;
               end
            end
            S_CLEAR: state <= S_FETCH;
            S_FETCH: begin
               fetch_idx <= fetch_idx + K_ONE;
               if (fetch_idx == k_len - K_ONE) begin
                  drain_cnt <= '0;
                  state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Completion is judged on done alone; valids still in flight are the array's concern.
               if (i_pa_computation_done) begin
                  state <= S_READ;
               end else if (drain_cnt == DRAIN_LAST) begin
                  o_timeout_err <= 1'b1;
                  state         <= S_IDLE;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            S_READ: state <= S_CAPTURE;
            S_CAPTURE: begin
               o_result_matrix <= i_pa_result_matrix;
               o_overflow      <= overflow_acc | i_pa_overflow_detected;
               state           <= S_HOLD;
            end
            S_HOLD: begin
               if (i_result_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (start_ok) overflow_acc <= 1'b0;
         else if (ovf_window) overflow_acc <= overflow_acc | i_pa_overflow_detected;
      end
   end

   // Memory data lands one cycle after the strobe, so the array sees valid two cycles after it.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         rd_en_d1        <= 1'b0;
         o_pa_data_valid <= 1'b0;
         o_pa_a_vector   <= '0;
         o_pa_b_vector   <= '0;
      end else begin
         rd_en_d1        <= o_mem_rd_en;
         o_pa_data_valid <= rd_en_d1;
         o_pa_a_vector   <= rd_en_d1 ? i_a_rdata : '0;
         o_pa_b_vector   <= rd_en_d1 ? i_b_rdata : '0;
      end
   end

endmodule

// File: tb/tb_pa3x3_tile_controller.sv
// Bench for pa3x3_tile_controller: memory model, array stub and a queue-based scoreboard
// for addresses, operand vectors and held results.
module tb_pa3x3_tile_controller;

   typedef logic [288:0] w_t;

   logic          clk = 1'b0;
   logic          i_reset;
   logic          i_start;
   logic [7:0]    i_k_len;
   logic [7:0]    i_a_base;
   logic [7:0]    i_b_base;
   logic          o_busy;
   logic          o_mem_rd_en;
   logic [7:0]    o_a_addr;
   logic [7:0]    o_b_addr;
   logic [23:0]   i_a_rdata;
   logic [23:0]   i_b_rdata;
   logic [23:0]   o_pa_a_vector;
   logic [23:0]   o_pa_b_vector;
   logic          o_pa_data_valid;
   logic          o_pa_read_enable;
   logic          o_pa_clear_acc;
   logic [287:0]  i_pa_result_matrix;
   logic          i_pa_computation_done;
   logic          i_pa_overflow_detected;
   logic [287:0]  o_result_matrix;
   logic          o_result_valid;
   logic          i_result_ready;
   logic          o_overflow;
   logic          o_timeout_err;
   logic [2:0]    o_dbg_state;

   int total = 0;
   int bad   = 0;

   logic [15:0]  addr_q[$];
   logic [47:0]  vec_q[$];
   logic [288:0] exp_q[$];

   int stub_k     = 0;
   int stub_delay = -1;
   int stub_vcnt  = 0;
   int stub_timer = -1;

   int c_clear, c_rd_first, c_rd_last, c_dv_first, c_dv_last, c_read, c_rv_first;
   int c_idle, c_err, clear_cnt, read_cnt;
   logic err_n1;
   logic [287:0] last_m;

   pa3x3_tile_controller #(
      .DATA_WIDTH(8), .ACC_WIDTH(32), .ADDR_WIDTH(8), .K_WIDTH(8), .DRAIN_TIMEOUT(16)
   ) dut (
      .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_k_len(i_k_len),
      .i_a_base(i_a_base), .i_b_base(i_b_base), .o_busy(o_busy),
      .o_mem_rd_en(o_mem_rd_en), .o_a_addr(o_a_addr), .o_b_addr(o_b_addr),
      .i_a_rdata(i_a_rdata), .i_b_rdata(i_b_rdata),
      .o_pa_a_vector(o_pa_a_vector), .o_pa_b_vector(o_pa_b_vector),
      .o_pa_data_valid(o_pa_data_valid), .o_pa_read_enable(o_pa_read_enable),
      .o_pa_clear_acc(o_pa_clear_acc), .i_pa_result_matrix(i_pa_result_matrix),
      .i_pa_computation_done(i_pa_computation_done),
      .i_pa_overflow_detected(i_pa_overflow_detected),
      .o_result_matrix(o_result_matrix), .o_result_valid(o_result_valid),
      .i_result_ready(i_result_ready), .o_overflow(o_overflow),
      .o_timeout_err(o_timeout_err), .o_dbg_state(o_dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check_val(input string tag, input w_t obs, input w_t exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] mem_a(input logic [7:0] ad);
      return {ad ^ 8'h3C, ad + 8'd7, ~ad};
   endfunction

   function automatic logic [23:0] mem_b(input logic [7:0] ad);
      return {ad + 8'd1, ad ^ 8'hA5, ad};
   endfunction

   task automatic check_all_zero(input string tag);
      check_val({tag, "_busy"},    w_t'(o_busy), w_t'(0));
      check_val({tag, "_rd_en"},   w_t'(o_mem_rd_en), w_t'(0));
      check_val({tag, "_addr"},    w_t'({o_a_addr, o_b_addr}), w_t'(0));
      check_val({tag, "_vec"},     w_t'({o_pa_a_vector, o_pa_b_vector}), w_t'(0));
      check_val({tag, "_dv"},      w_t'(o_pa_data_valid), w_t'(0));
      check_val({tag, "_rden"},    w_t'(o_pa_read_enable), w_t'(0));
      check_val({tag, "_clr"},     w_t'(o_pa_clear_acc), w_t'(0));
      check_val({tag, "_matrix"},  w_t'(o_result_matrix), w_t'(0));
      check_val({tag, "_rv"},      w_t'(o_result_valid), w_t'(0));
      check_val({tag, "_ovf"},     w_t'(o_overflow), w_t'(0));
      check_val({tag, "_tmo"},     w_t'(o_timeout_err), w_t'(0));
      check_val({tag, "_state"},   w_t'(o_dbg_state), w_t'(0));
   endtask

   // ---------------- operand memory model (synchronous read) ----------------
   always @(posedge clk) begin
      if (o_mem_rd_en) begin
         i_a_rdata <= mem_a(o_a_addr);
         i_b_rdata <= mem_b(o_b_addr);
      end else begin
         i_a_rdata <= 24'($urandom);
         i_b_rdata <= 24'($urandom);
      end
   end

   // ---------------- array stub: done stub_delay cycles after the K-th valid ----------------
   always @(negedge clk) begin
      if (i_reset) begin
         stub_vcnt = 0;
         stub_timer = -1;
         i_pa_computation_done = 1'b0;
      end else begin
         i_pa_computation_done = 1'b0;
         if (o_pa_clear_acc) begin
            stub_vcnt = 0;
            stub_timer = -1;
         end
         if (stub_timer > 0) begin
            stub_timer--;
            if (stub_timer == 0) begin
               i_pa_computation_done = 1'b1;
               stub_timer = -1;
            end
         end
         if (o_pa_data_valid) begin
            stub_vcnt++;
            if (stub_vcnt == stub_k && stub_delay > 0) stub_timer = stub_delay;
         end
      end
   end

   // ---------------- scoreboard monitor, sampled late in the low phase ----------------
   always @(negedge clk) begin
      logic [15:0]  ea;
      logic [47:0]  ev;
      logic [288:0] er;
      #3;
      if (o_mem_rd_en) begin
         if (addr_q.size() == 0) check_val("rd_extra", w_t'(addr_q.size()), w_t'(1));
         else begin
            ea = addr_q.pop_front();
            check_val("rd_addr", w_t'({o_a_addr, o_b_addr}), w_t'(ea));
         end
      end
      if (o_pa_data_valid) begin
         if (vec_q.size() == 0) check_val("dv_extra", w_t'(vec_q.size()), w_t'(1));
         else begin
            ev = vec_q.pop_front();
            check_val("pa_vectors", w_t'({o_pa_a_vector, o_pa_b_vector}), w_t'(ev));
         end
      end else begin
         check_val("vec_idle", w_t'({o_pa_a_vector, o_pa_b_vector}), w_t'(0));
      end
      if (o_result_valid) begin
         if (exp_q.size() == 0) check_val("rv_unexpected", w_t'(exp_q.size()), w_t'(1));
         else begin
            check_val("result_matrix", w_t'(o_result_matrix), w_t'(exp_q[0][287:0]));
            check_val("result_ovf", w_t'(o_overflow), w_t'(exp_q[0][288]));
            if (i_result_ready) er = exp_q.pop_front();
         end
      end
   end

   // ---------------- driver: one full tile ----------------
   task automatic run_tile(input int k, input logic [7:0] ab, input logic [7:0] bb,
                           input int ddelay, input int rdy_lag, input bit ovf,
                           input bit hold_start, input logic [31:0] fill);
      logic [287:0] m;
      logic [7:0]   aa, ba;
      int           hold_cnt;
      bit           fin;
      for (int i = 0; i < 9; i++) m[i*32 +: 32] = (fill != 0) ? fill : $urandom;
      last_m = m;
      stub_k = k;
      stub_delay = ddelay;
      i_pa_result_matrix = m;
      for (int j = 0; j < k; j++) begin
         aa = ab + 8'(j);
         ba = bb + 8'(j);
         addr_q.push_back({aa, ba});
         vec_q.push_back({mem_a(aa), mem_b(ba)});
      end
      if (ddelay > 0) exp_q.push_back({ovf, m});
      c_clear = -1; c_rd_first = -1; c_rd_last = -1; c_dv_first = -1; c_dv_last = -1;
      c_read = -1; c_rv_first = -1; c_idle = -1; c_err = -1;
      clear_cnt = 0; read_cnt = 0; hold_cnt = 0; fin = 1'b0; err_n1 = 1'b1;
      i_start = 1'b1;
      i_k_len = 8'(k);
      i_a_base = ab;
      i_b_base = bb;
      i_result_ready = (rdy_lag == 0);
      for (int n = 1; n <= 300 && !fin; n++) begin
         @(negedge clk);
         i_start = 1'b0;
         i_pa_overflow_detected = ovf && (n == 2);
         if (n == 1) err_n1 = o_timeout_err;
         if (o_pa_clear_acc) begin clear_cnt++; c_clear = n; end
         if (o_mem_rd_en) begin
            if (c_rd_first < 0) c_rd_first = n;
            c_rd_last = n;
         end
         if (o_pa_data_valid) begin
            if (c_dv_first < 0) c_dv_first = n;
            c_dv_last = n;
         end
         if (o_pa_read_enable) begin read_cnt++; c_read = n; end
         if (o_result_valid) begin
            if (hold_cnt == 0) c_rv_first = n;
            i_result_ready = (hold_cnt >= rdy_lag);
            if (hold_start && hold_cnt == 1) begin
               i_start = 1'b1;
               i_k_len = 8'd2;
            end
            hold_cnt++;
         end
         if (o_timeout_err && c_err < 0) c_err = n;
         if (!o_busy) begin c_idle = n; fin = 1'b1; end
      end
      if (!fin) check_val("tile_end", w_t'(o_busy), w_t'(0));
      check_val("hold_cycles", w_t'(hold_cnt), w_t'((ddelay > 0) ? rdy_lag + 1 : 0));
      check_val("addr_q_left", w_t'(addr_q.size()), w_t'(0));
      check_val("vec_q_left", w_t'(vec_q.size()), w_t'(0));
      check_val("exp_q_left", w_t'(exp_q.size()), w_t'(0));
      i_result_ready = 1'b0;
      i_pa_overflow_detected = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      i_reset = 1'b1;
      i_start = 1'b0;
      i_k_len = '0;
      i_a_base = '0;
      i_b_base = '0;
      i_pa_result_matrix = '0;
      i_pa_computation_done = 1'b0;
      i_pa_overflow_detected = 1'b0;
      i_result_ready = 1'b0;
      i_a_rdata = '0;
      i_b_rdata = '0;
      repeat (2) @(negedge clk);
      check_all_zero("rst");
      i_reset = 1'b0;
      @(negedge clk);

      // basic tile: exact cycle placement of every phase
      run_tile(3, 8'h10, 8'h20, 4, 0, 1'b0, 1'b0, 32'h0000_0007);
      check_val("t1_clear_cycle", w_t'(c_clear), w_t'(1));
      check_val("t1_clear_count", w_t'(clear_cnt), w_t'(1));
      check_val("t1_rd_first", w_t'(c_rd_first), w_t'(2));
      check_val("t1_rd_last", w_t'(c_rd_last), w_t'(4));
      check_val("t1_dv_first", w_t'(c_dv_first), w_t'(4));
      check_val("t1_dv_last", w_t'(c_dv_last), w_t'(6));
      check_val("t1_read_count", w_t'(read_cnt), w_t'(1));
      check_val("t1_read_cycle", w_t'(c_read), w_t'(11));
      check_val("t1_rv_cycle", w_t'(c_rv_first), w_t'(13));
      check_val("t1_idle_cycle", w_t'(c_idle), w_t'(14));

      // address wrap
      run_tile(4, 8'hFE, 8'h30, 3, 0, 1'b0, 1'b0, 32'h0);
      check_val("t2_rd_last", w_t'(c_rd_last), w_t'(5));

      // consumer stalls 5 cycles; a start during HOLD must be ignored
      run_tile(2, 8'h40, 8'h50, 2, 5, 1'b0, 1'b1, 32'h0);
      repeat (3) begin
         @(negedge clk);
         check_val("t3_stays_idle", w_t'(o_busy), w_t'(0));
      end

      // overflow during FETCH, then a clean tile
      run_tile(5, 8'h60, 8'h70, 3, 1, 1'b1, 1'b0, 32'h0);
      check_val("t4_ovf_kept", w_t'(o_overflow), w_t'(1));
      check_val("t4_matrix_kept", w_t'(o_result_matrix), w_t'(last_m));
      run_tile(3, 8'h80, 8'h90, 5, 0, 1'b0, 1'b0, 32'h0);
      check_val("t5_ovf_clean", w_t'(o_overflow), w_t'(0));

      // done never arrives: 16 DRAIN cycles (4..19) then abort
      run_tile(2, 8'hA0, 8'hB0, -1, 0, 1'b0, 1'b0, 32'h0);
      check_val("t6_err_cycle", w_t'(c_err), w_t'(20));
      check_val("t6_idle_cycle", w_t'(c_idle), w_t'(20));
      repeat (3) @(negedge clk);
      check_val("t6_err_sticky", w_t'(o_timeout_err), w_t'(1));
      check_val("t6_no_rv", w_t'(o_result_valid), w_t'(0));
      run_tile(1, 8'hC0, 8'hD0, 3, 0, 1'b0, 1'b0, 32'h0);
      check_val("t7_err_cleared", w_t'(err_n1), w_t'(0));
      check_val("t7_err_after", w_t'(o_timeout_err), w_t'(0));

      // reset in FETCH at K=8, j=3 (cycle 5)
      for (int j = 0; j < 8; j++) begin
         addr_q.push_back({8'h05 + 8'(j), 8'h85 + 8'(j)});
         vec_q.push_back({mem_a(8'h05 + 8'(j)), mem_b(8'h85 + 8'(j))});
      end
      stub_k = 8;
      stub_delay = 3;
      i_start = 1'b1;
      i_k_len = 8'd8;
      i_a_base = 8'h05;
      i_b_base = 8'h85;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         i_start = 1'b0;
      end
      check_val("t8_fetch_j3", w_t'({o_mem_rd_en, o_a_addr, o_b_addr}), w_t'({1'b1, 8'h08, 8'h88}));
      i_reset = 1'b1;
      #1;
      check_all_zero("mid_rst");
      addr_q.delete();
      vec_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      i_reset = 1'b0;
      @(negedge clk);

      // K=0 start is ignored
      i_start = 1'b1;
      i_k_len = 8'd0;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         i_start = 1'b0;
         check_val("t9_k0_busy", w_t'({o_busy, o_pa_clear_acc}), w_t'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pa3x3_tile_controller.md
Name: pa3x3_tile_controller

Overview:
Sequences one 3x3 tile multiply on processing_array_3x3 and runs the handshake to a downstream result consumer. On a start command it clears the array accumulators and streams K operand vector pairs from synchronous operand memory into the array. It then waits for the array's done flag, reads out the 288-bit result and holds it until the consumer accepts it. It sits between the layer scheduler (start/base/K) and the array instance.

Parameters:
DATA_WIDTH, 8, operand element width; vectors are 3*DATA_WIDTH.
ACC_WIDTH, 32, accumulator width; result bus is 9*ACC_WIDTH.
ADDR_WIDTH, 8, operand memory address width.
K_WIDTH, 8, width of the K-depth field.
DRAIN_TIMEOUT, 16, maximum number of DRAIN cycles to wait for done.

Ports:
clk  in  1  clock, all logic on rising edge
i_reset  in  1  asynchronous, active-high reset
i_start  in  1  start pulse; accepted only in IDLE
i_k_len  in  K_WIDTH  number of vector pairs; sampled with i_start
i_a_base  in  ADDR_WIDTH  A operand base address; sampled with i_start
i_b_base  in  ADDR_WIDTH  B operand base address; sampled with i_start
o_busy  out  1  high in every state except IDLE
o_mem_rd_en  out  1  operand memory read strobe
o_a_addr  out  ADDR_WIDTH  A read address
o_b_addr  out  ADDR_WIDTH  B read address
i_a_rdata  in  3*DATA_WIDTH  A data, valid one cycle after o_mem_rd_en
i_b_rdata  in  3*DATA_WIDTH  B data, valid one cycle after o_mem_rd_en
o_pa_a_vector  out  3*DATA_WIDTH  to array i_a_vector
o_pa_b_vector  out  3*DATA_WIDTH  to array i_b_vector
o_pa_data_valid  out  1  to array i_data_valid
o_pa_read_enable  out  1  to array i_read_enable
o_pa_clear_acc  out  1  to array i_clear_acc
i_pa_result_matrix  in  9*ACC_WIDTH  from array
i_pa_computation_done  in  1  from array
i_pa_overflow_detected  in  1  from array
o_result_matrix  out  9*ACC_WIDTH  captured result, stable while o_result_valid is high
o_result_valid  out  1  result handshake valid
i_result_ready  in  1  result handshake ready
o_overflow  out  1  overflow flag for the held result
o_timeout_err  out  1  sticky; tile aborted because done never arrived

Behaviour:
- Reset (async, i_reset=1): FSM goes to IDLE. All outputs are 0, including vectors, result matrix and both error flags. Internal counters are 0. Reset mid-tile aborts the tile with no result.
- States: IDLE, CLEAR, FETCH, DRAIN, READ, CAPTURE, HOLD.
- IDLE: i_start=1 with i_k_len!=0 latches K/bases, clears o_overflow and o_timeout_err, and moves to CLEAR. i_start with i_k_len=0 is ignored. i_start outside IDLE is ignored.
- CLEAR: o_pa_clear_acc=1 for exactly one cycle, then FETCH.
- FETCH: lasts exactly K cycles with o_mem_rd_en=1. On fetch cycle j (0..K-1): o_a_addr=a_base+j and o_b_addr=b_base+j, both modulo 2^ADDR_WIDTH (wrap permitted). After the K-th cycle, go to DRAIN.
- Operand pipeline: registered delay on rd_en, then a register on rdata. o_pa_data_valid equals o_mem_rd_en delayed by 2 cycles. The vectors are registered copies of rdata. When data_valid=0 the vectors are held at 0. Exactly K data_valid pulses per tile, back to back.
- DRAIN: a cycle counter starts at 0 on entry. i_pa_computation_done=1 moves to READ, even if the in-flight valids are still draining. Completion is judged on done only. If the counter reaches DRAIN_TIMEOUT with no done, o_timeout_err=1 (sticky) and the FSM returns to IDLE with no result.
- READ: o_pa_read_enable=1 for one cycle, then CAPTURE.
- CAPTURE: o_result_matrix is loaded from i_pa_result_matrix and o_overflow from the accumulated overflow flag, then HOLD.
- Overflow: overflow_acc ORs i_pa_overflow_detected on every cycle from CLEAR through CAPTURE inclusive.
- HOLD: o_result_valid=1. o_result_matrix and o_overflow are stable. The transfer happens on the cycle with o_result_valid=1 and i_result_ready=1; the FSM then goes to IDLE and o_result_valid=0 on the next cycle. i_result_ready held high before HOLD costs no extra cycle.
- o_result_matrix and o_overflow keep their value after the transfer until the next CAPTURE.
- Latency: start accepted at cycle 0 gives CLEAR at cycle 1 and FETCH at cycles 2..K+1. The last o_pa_data_valid is at cycle K+3. READ comes one cycle after done is observed, and o_result_valid rises two cycles after READ.

Test Plan:
- K=3, a_base=0x10, b_base=0x20, array stub raises done 4 cycles after the last valid, ready=1 -> clear at cycle 1. Addresses 0x10..0x12 and 0x20..0x22 at cycles 2..4. data_valid at cycles 4..6. One read_enable pulse. o_result_valid held 1 cycle with the stub matrix (e.g. all 32'h0000_0007).
- a_base=0xFE, K=4 -> A addresses 0xFE, 0xFF, 0x00, 0x01.
- Result ready held low 5 cycles in HOLD -> o_result_valid and o_result_matrix stable for 6 cycles, then IDLE. A start pulse during HOLD is ignored.
- Stub never raises done, DRAIN_TIMEOUT=16 -> o_timeout_err=1 after 16 DRAIN cycles, o_busy=0, no o_result_valid. The next start clears o_timeout_err.
- Overflow pulsed for 1 cycle during FETCH -> o_overflow=1 with the result. The next clean tile gives o_overflow=0.
- Reset asserted in FETCH at K=8 j=3 -> all outputs 0 immediately. i_k_len=0 start -> o_busy stays 0.
